// File: rtl/uart_core_cfg.sv
// Full-duplex UART with configurable data width, parity mode and stop-bit count.
// Latency: tx drives the start bit the cycle after accept; rx_valid rises the cycle after the stop-bit centre sample.
// Backpressure: tx_ready is high only when idle; a one-entry RX holding register drops new frames (rx_overrun) while full.
module uart_core_cfg #(
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD      = 57600,
    parameter int DATA_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_parity_err,
    output logic              rx_frame_err,
    output logic              rx_overrun
);

    localparam int CPB      = CLK_HZ / BAUD;
    localparam int HALF     = CPB / 2;
    localparam int STOP_LEN = STOP_BITS * CPB;
    localparam int CW       = $clog2(STOP_LEN + 1);

    localparam logic [CW-1:0] CPB_M1   = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
    localparam logic [CW-1:0] STOP_M1  = CW'(STOP_LEN - 1);
    localparam logic [3:0]    LAST_BIT = 4'(DATA_W - 1);
    localparam logic          HAS_PAR  = (PARITY != 0);
    localparam logic          ODD      = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t              tx_st, tx_st_n;
    logic [CW-1:0]       tx_cnt, tx_cnt_n;
    logic [3:0]          tx_bit, tx_bit_n;
    logic [DATA_W-1:0]   tx_sh, tx_sh_n;
    logic                tx_par, tx_par_n;
    logic                tx_n;

    // TX next-state: each bit is held CPB cycles; tx is registered so it changes on bit boundaries only
    always_comb begin
        tx_st_n  = tx_st;
        tx_cnt_n = tx_cnt + 1'b1;
        tx_bit_n = tx_bit;
        tx_sh_n  = tx_sh;
        tx_par_n = tx_par;
        tx_n     = tx;
        case (tx_st)
            S_IDLE: begin
                tx_cnt_n = '0;
                tx_n     = 1'b1;
                if (tx_valid && tx_ready) begin
                    tx_st_n  = S_START;
                    tx_n     = 1'b0;
                    tx_sh_n  = tx_data;
                    tx_par_n = (^tx_data) ^ ODD;
                end
            end
            S_START: begin
                if (tx_cnt == CPB_M1) begin
                    tx_cnt_n = '0;
                    tx_bit_n = '0;
                    tx_st_n  = S_DATA;
                    tx_n     = tx_sh[0];
                end
            end
            S_DATA: begin
                if (tx_cnt == CPB_M1) begin
                    tx_cnt_n = '0;
                    if (tx_bit == LAST_BIT) begin
                        if (HAS_PAR) begin
                            tx_st_n = S_PARITY;
                            tx_n    = tx_par;
                        end else begin
                            tx_st_n = S_STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        tx_bit_n = tx_bit + 1'b1;
                        tx_sh_n  = tx_sh >> 1;
                        tx_n     = tx_sh[1];
                    end
                end
            end
            S_PARITY: begin
                if (tx_cnt == CPB_M1) begin
                    tx_cnt_n = '0;
                    tx_st_n  = S_STOP;
                    tx_n     = 1'b1;
                end
            end
            S_STOP: begin
                if (tx_cnt == STOP_M1) begin
                    tx_cnt_n = '0;
                    tx_st_n  = S_IDLE;
                    tx_n     = 1'b1;
                end
            end
            default: begin
                tx_cnt_n = '0;
                tx_st_n  = S_IDLE;
                tx_n     = 1'b1;
            end
        endcase
    end

    // TX state register; tx_ready is registered from the next state so it is low during reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_st    <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
            tx       <= 1'b1;
            tx_ready <= 1'b0;
        end else begin
            tx_st    <= tx_st_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_sh    <= tx_sh_n;
            tx_par   <= tx_par_n;
            tx       <= tx_n;
            tx_ready <= (tx_st_n == S_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic rx_meta, rxs;

    // Two-flop synchroniser for the asynchronous line, idles high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    state_t              rx_st, rx_st_n;
    logic [CW-1:0]       rx_cnt, rx_cnt_n;
    logic [3:0]          rx_bit, rx_bit_n;
    logic [DATA_W-1:0]   rx_sh, rx_sh_n;
    logic                rx_perr, rx_perr_n;
    logic                armed, armed_n;
    logic                rx_done;

    // RX next-state: half-bit start check, then one sample per bit centre; re-arm only after the line is seen high
    always_comb begin
        rx_st_n   = rx_st;
        rx_cnt_n  = rx_cnt + 1'b1;
        rx_bit_n  = rx_bit;
        rx_sh_n   = rx_sh;
        rx_perr_n = rx_perr;
        armed_n   = armed;
        rx_done   = 1'b0;
        case (rx_st)
            S_IDLE: begin
                rx_cnt_n = '0;
                if (armed && !rxs) begin
                    rx_st_n = S_START;
                    armed_n = 1'b0;
                end else if (rxs) begin
                    armed_n = 1'b1;
                end
            end
            S_START: begin
                if (rx_cnt == HALF_M1) begin
                    rx_cnt_n = '0;
                    if (rxs) begin
                        rx_st_n = S_IDLE;
                    end else begin
                        rx_st_n   = S_DATA;
                        rx_bit_n  = '0;
                        rx_perr_n = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (rx_cnt == CPB_M1) begin
                    rx_cnt_n = '0;
                    rx_sh_n  = {rxs, rx_sh[DATA_W-1:1]};
                    if (rx_bit == LAST_BIT) begin
                        rx_st_n = HAS_PAR ? S_PARITY : S_STOP;
                    end else begin
                        rx_bit_n = rx_bit + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (rx_cnt == CPB_M1) begin
                    rx_cnt_n  = '0;
                    rx_perr_n = rxs ^ (^rx_sh) ^ ODD;
                    rx_st_n   = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_cnt == CPB_M1) begin
                    rx_cnt_n = '0;
                    rx_done  = 1'b1;
                    rx_st_n  = S_IDLE;
                end
            end
            default: begin
                rx_cnt_n = '0;
                rx_st_n  = S_IDLE;
                armed_n  = 1'b0;
            end
        endcase
    end

    // RX state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_st   <= S_IDLE;
            rx_cnt  <= '0;
            rx_bit  <= '0;
            rx_sh   <= '0;
            rx_perr <= 1'b0;
            armed   <= 1'b0;
        end else begin
            rx_st   <= rx_st_n;
            rx_cnt  <= rx_cnt_n;
            rx_bit  <= rx_bit_n;
            rx_sh   <= rx_sh_n;
            rx_perr <= rx_perr_n;
            armed   <= armed_n;
        end
    end

    // Holding register: load on completion if empty or being drained this cycle, otherwise drop and flag overrun
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (rx_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_valid      <= 1'b1;
                    rx_data       <= rx_sh;
                    rx_parity_err <= rx_perr;
                    rx_frame_err  <= ~rxs;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_core_cfg.sv
// Bench for uart_core_cfg: instance a is 8N1, instance b is 8E2 with tx looped back to rx.
// Both run at 16 clocks per bit; a frame-level model predicts every output each cycle.
// Directed vectors with literal expectations pin the model.
module tb_uart_core_cfg;

    localparam int CPB  = 16;
    localparam int HALF = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       tx_valid_a, tx_ready_a, tx_a, rx_a, rx_valid_a, rx_ready_a, perr_a, ferr_a, ovr_a;
    logic [7:0] tx_data_a, rx_data_a;
    logic       tx_valid_b, tx_ready_b, tx_b, rx_b, rx_valid_b, rx_ready_b, perr_b, ferr_b, ovr_b;
    logic [7:0] tx_data_b, rx_data_b;
    logic       force_par;

    assign rx_b = force_par ? 1'b1 : tx_b;

    uart_core_cfg #(.CLK_HZ(921600), .BAUD(57600), .DATA_W(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .tx_valid(tx_valid_a), .tx_data(tx_data_a), .tx_ready(tx_ready_a), .tx(tx_a),
        .rx(rx_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
        .rx_parity_err(perr_a), .rx_frame_err(ferr_a), .rx_overrun(ovr_a)
    );

    uart_core_cfg #(.CLK_HZ(921600), .BAUD(57600), .DATA_W(8), .PARITY(2), .STOP_BITS(2)) u_b (
        .clk(clk), .rst_n(rst_n),
        .tx_valid(tx_valid_b), .tx_data(tx_data_b), .tx_ready(tx_ready_b), .tx(tx_b),
        .rx(rx_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
        .rx_parity_err(perr_b), .rx_frame_err(ferr_b), .rx_overrun(ovr_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ovr_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- model ----------------
    logic        m_tx[2], m_ready[2];
    bit          m_act[2];
    int          m_k[2], m_len[2];
    logic [15:0] m_bits[2];
    logic        m_vld[2], m_pe[2], m_fe[2], m_ov[2];
    logic [7:0]  m_dat[2];
    bit          p_vld[2];
    int          p_edge[2];
    logic [7:0]  p_dat[2];
    logic        p_pe[2], p_fe[2];
    bit          b_force;
    logic        tvv, rdy;
    logic [7:0]  tdd;
    int          idx;

    // Frame-level model, advanced once per clock edge from the inputs seen at that edge
    always @(posedge clk) begin
        cyc++;
        for (int u = 0; u < 2; u++) begin
            tvv = (u == 0) ? tx_valid_a : tx_valid_b;
            tdd = (u == 0) ? tx_data_a  : tx_data_b;
            rdy = (u == 0) ? rx_ready_a : rx_ready_b;
            if (!rst_n) begin
                m_act[u] = 0; m_tx[u] = 1'b1; m_ready[u] = 1'b0;
                m_vld[u] = 1'b0; m_dat[u] = 8'h00; m_pe[u] = 1'b0; m_fe[u] = 1'b0; m_ov[u] = 1'b0;
                p_vld[u] = 0;
            end else begin
                // transmitter: list the frame's bits, then replay each for CPB cycles
                if (!m_act[u] && m_ready[u] && tvv) begin
                    m_bits[u] = '0;
                    for (int i = 0; i < 8; i++) m_bits[u][1+i] = tdd[i];
                    idx = 9;
                    if (u == 1) begin
                        m_bits[u][9] = ^tdd;
                        idx = 10;
                    end
                    for (int s = 0; s < ((u == 1) ? 2 : 1); s++) begin
                        m_bits[u][idx] = 1'b1;
                        idx++;
                    end
                    m_len[u] = idx * CPB;
                    m_k[u]   = 0;
                    m_act[u] = 1;
                    if (u == 1) begin
                        // loopback: line low seen at next edge, +2 sync, half bit, 10 more bit times to stop centre
                        p_vld[1]  = 1;
                        p_edge[1] = cyc + 1 + 2 + HALF + 10 * CPB;
                        p_dat[1]  = tdd;
                        p_pe[1]   = b_force;
                        p_fe[1]   = 1'b0;
                    end
                end
                if (m_act[u]) begin
                    m_tx[u]    = m_bits[u][m_k[u] / CPB];
                    m_ready[u] = 1'b0;
                    m_k[u]++;
                    if (m_k[u] == m_len[u]) m_act[u] = 0;
                end else begin
                    m_tx[u]    = 1'b1;
                    m_ready[u] = 1'b1;
                end
                // receiver holding register
                m_ov[u] = 1'b0;
                if (p_vld[u] && p_edge[u] == cyc) begin
                    p_vld[u] = 0;
                    if (!m_vld[u] || rdy) begin
                        m_vld[u] = 1'b1; m_dat[u] = p_dat[u]; m_pe[u] = p_pe[u]; m_fe[u] = p_fe[u];
                    end else begin
                        m_ov[u] = 1'b1;
                    end
                end else if (m_vld[u] && rdy) begin
                    m_vld[u] = 1'b0;
                end
            end
        end
    end

    // Compare every output of both instances against the model on each falling edge
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("tx_a", tx_a, m_tx[0]);
            chk("tx_ready_a", tx_ready_a, m_ready[0]);
            chk("rx_valid_a", rx_valid_a, m_vld[0]);
            chk("rx_data_a", rx_data_a, m_dat[0]);
            chk("perr_a", perr_a, m_pe[0]);
            chk("ferr_a", ferr_a, m_fe[0]);
            chk("ovr_a", ovr_a, m_ov[0]);
            chk("tx_b", tx_b, m_tx[1]);
            chk("tx_ready_b", tx_ready_b, m_ready[1]);
            chk("rx_valid_b", rx_valid_b, m_vld[1]);
            chk("rx_data_b", rx_data_b, m_dat[1]);
            chk("perr_b", perr_b, m_pe[1]);
            chk("ferr_b", ferr_b, m_fe[1]);
            chk("ovr_b", ovr_b, m_ov[1]);
            if (ovr_a) ovr_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_tx(input int u, input logic [7:0] d);
        @(negedge clk);
        if (u == 0) begin tx_valid_a = 1'b1; tx_data_a = d; end
        else        begin tx_valid_b = 1'b1; tx_data_b = d; end
        @(negedge clk);
        tx_valid_a = 1'b0;
        tx_valid_b = 1'b0;
    endtask

    task automatic tx_capture(input int u, output int low, output logic [11:0] cap);
        int j;
        j   = 0;
        cap = '0;
        while ((((u == 0) ? tx_ready_a : tx_ready_b) == 1'b0) && j < 400) begin
            if (j % CPB == HALF && j < 12 * CPB) cap[j/CPB] = (u == 0) ? tx_a : tx_b;
            j++;
            @(negedge clk);
        end
        low = j;
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop_v);
        @(negedge clk);
        // line low first seen at next edge, +2 sync, half bit, 9 more bit times to stop centre
        p_vld[0]  = 1;
        p_edge[0] = cyc + 1 + 2 + HALF + 9 * CPB;
        p_dat[0]  = d;
        p_pe[0]   = 1'b0;
        p_fe[0]   = ~stop_v;
        rx_a = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_a = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx_a = stop_v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic consume(input int u);
        @(negedge clk);
        if (u == 0) rx_ready_a = 1'b1; else rx_ready_b = 1'b1;
        @(negedge clk);
        rx_ready_a = 1'b0;
        rx_ready_b = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    int         low;
    logic [11:0] cap;

    initial begin
        rst_n = 1'b0;
        tx_valid_a = 1'b0; tx_data_a = 8'h00; rx_a = 1'b1; rx_ready_a = 1'b0;
        tx_valid_b = 1'b0; tx_data_b = 8'h00; rx_ready_b = 1'b0;
        force_par = 1'b0; b_force = 0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx_a, 1);
        chk("rst_tx_ready", tx_ready_a, 0);
        chk("rst_rx_valid", rx_valid_a, 0);
        chk("rst_rx_data", rx_data_a, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", tx_ready_a, 1);

        // 8N1 transmit of F3: start, 1,1,0,0,1,1,1,1, stop
        send_tx(0, 8'hF3);
        tx_capture(0, low, cap);
        chk("f3_ready_low", low, 160);
        chk("f3_bits", 32'(cap[9:0]), 32'h3E6);
        chk("f3_ready_back", tx_ready_a, 1);

        // 8N1 receive of EB, held until consumed
        send_rx(8'hEB, 1'b1);
        chk("eb_valid", rx_valid_a, 1);
        chk("eb_data", rx_data_a, 8'hEB);
        chk("eb_perr", perr_a, 0);
        chk("eb_ferr", ferr_a, 0);
        repeat (20) @(negedge clk);
        chk("eb_hold", rx_valid_a, 1);
        consume(0);
        chk("eb_cleared", rx_valid_a, 0);

        // 8E2 loopback of 5A: parity bit 0, two stop bits
        send_tx(1, 8'h5A);
        tx_capture(1, low, cap);
        chk("5a_ready_low", low, 192);
        chk("5a_bits", 32'(cap), 32'hCB4);
        chk("5a_parity_bit", cap[9], 0);
        chk("5a_rx_valid", rx_valid_b, 1);
        chk("5a_rx_data", rx_data_b, 8'h5A);
        chk("5a_perr", perr_b, 0);
        consume(1);

        // same word with the parity bit forced high on the line
        b_force = 1;
        send_tx(1, 8'h5A);
        repeat (146) @(negedge clk);
        force_par = 1'b1;
        repeat (12) @(negedge clk);
        force_par = 1'b0;
        repeat (60) @(negedge clk);
        chk("5a_forced_valid", rx_valid_b, 1);
        chk("5a_forced_data", rx_data_b, 8'h5A);
        chk("5a_forced_perr", perr_b, 1);
        chk("5a_forced_ferr", ferr_b, 0);
        consume(1);
        b_force = 0;

        // stop bit low, line stays low: one flagged word, no re-trigger
        send_rx(8'h00, 1'b0);
        repeat (200) @(negedge clk);
        chk("ferr_valid", rx_valid_a, 1);
        chk("ferr_data", rx_data_a, 8'h00);
        chk("ferr_flag", ferr_a, 1);
        chk("ferr_perr", perr_a, 0);
        rx_a = 1'b1;
        repeat (20) @(negedge clk);
        consume(0);

        // short low glitch is rejected, next frame still received
        @(negedge clk);
        rx_a = 1'b0;
        repeat (4) @(negedge clk);
        rx_a = 1'b1;
        repeat (60) @(negedge clk);
        chk("glitch_no_valid", rx_valid_a, 0);
        send_rx(8'h3C, 1'b1);
        chk("post_glitch_data", rx_data_a, 8'h3C);
        consume(0);

        // overrun: second frame dropped while first is held
        ovr_cnt = 0;
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        repeat (5) @(negedge clk);
        chk("ovr_pulses", ovr_cnt, 1);
        chk("ovr_data", rx_data_a, 8'h11);
        chk("ovr_valid", rx_valid_a, 1);
        consume(0);
        chk("ovr_cleared", rx_valid_a, 0);

        // one-cycle reset during the 4th data bit
        send_tx(0, 8'hA5);
        repeat (70) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_tx", tx_a, 1);
        chk("midrst_ready", tx_ready_a, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready_back", tx_ready_a, 1);
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
